// File: rtl/bus_target_mem.sv
// Memory-mapped bus target: word storage with byte-strobe writes and an out-of-range error response.
// Latency: ready rises 1+WAIT_STATES edges after the accepting edge; one transfer per 2+WAIT_STATES cycles.
// Backpressure: none; new requests are sampled only in IDLE, and inputs are ignored while a transfer is in flight.
module bus_target_mem #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                read,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    output logic                error
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    // RESP is the access cycle; the registered ready pulse appears in the
    // following cycle, during which the FSM is already back in IDLE and can
    // sample the next request.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          wait_cnt;
    logic                read_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                in_range;
    logic [IDX_W-1:0]    idx;
    logic                accept;

    assign accept   = (state == IDLE) && enable;
    assign in_range = ({1'b0, addr_q} < DEPTH_W);
    assign idx      = addr_q[IDX_W-1:0];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: skip WAIT entirely when no wait states are configured.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = (WAIT_STATES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Wait counter: loaded at acceptance, counts down while in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 4'd0;
        end else if (accept) begin
            wait_cnt <= 4'(WAIT_STATES - 1);
        end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Request capture: fields are frozen at acceptance so later bus activity cannot disturb the transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (accept) begin
            read_q  <= read;
            addr_q  <= addr;
            wdata_q <= wdata;
            wstrb_q <= wstrb;
        end
    end

    // Response outputs: a single-cycle pulse, zero at every other time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready <= 1'b0;
            error <= 1'b0;
            rdata <= '0;
        end else begin
            ready <= 1'b0;
            error <= 1'b0;
            rdata <= '0;
            if (state == RESP) begin
                ready <= 1'b1;
                error <= !in_range;
                if (read_q && in_range) begin
                    rdata <= mem[idx];
                end
            end
        end
    end

    // Storage: cleared on reset; in-range writes update only the strobed bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if ((state == RESP) && !read_q && in_range) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_q[b]) begin
                    mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule
